// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one registered memory request per load/store,
// stalls upstream until ack or timeout, and registers the MEM/WB writeback set.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] ALUOutM_i,
  input  logic [31:0] WriteDataM_i,
  input  logic [3:0]  WA3M_i,
  input  logic        PCSrcM_i,
  input  logic        RegWriteM_i,
  input  logic        MemToRegM_i,
  input  logic        MemWriteM_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        StallM_o,
  output logic [31:0] ReadDataW_o,
  output logic [31:0] ALUOutW_o,
  output logic [3:0]  WA3W_o,
  output logic        PCSrcW_o,
  output logic        RegWriteW_o,
  output logic        MemToRegW_o,
  output logic        MemErr_o
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  // The last WAIT cycle is the one whose counter equals TIMEOUT-1, so a
  // silent memory sees exactly TIMEOUT cycles of mem_req.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] readDataW_q, readDataW_d;
  logic [31:0] aluOutW_q, aluOutW_d;
  logic [3:0]  wa3W_q, wa3W_d;
  logic        pcSrcW_q, pcSrcW_d;
  logic        regWriteW_q, regWriteW_d;
  logic        memToRegW_q, memToRegW_d;
  logic        memErr_q, memErr_d;

  logic access;
  logic isLoad;
  logic timeoutHit;

  assign access     = MemToRegM_i | MemWriteM_i;
  assign isLoad     = MemToRegM_i & ~MemWriteM_i;
  assign timeoutHit = (state_q == ST_WAIT) && (cnt_q == TIMEOUT_LAST);

  // Reset gates the stall so upstream is released as soon as reset asserts.
  assign StallM_o = ~reset_i &
                    (((state_q == ST_IDLE) & access) |
                     ((state_q == ST_WAIT) & ~mem_ack_i & ~timeoutHit));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    readDataW_d = readDataW_q;
    aluOutW_d   = aluOutW_q;
    wa3W_d      = wa3W_q;
    pcSrcW_d    = pcSrcW_q;
    regWriteW_d = regWriteW_q;
    memToRegW_d = memToRegW_q;
    memErr_d    = memErr_q;

    case (state_q)
      ST_IDLE: begin
        if (access) begin
          state_d     = ST_WAIT;
          cnt_d       = 8'd0;
          req_d       = 1'b1;
          we_d        = MemWriteM_i;
          addr_d      = ALUOutM_i;
          wdata_d     = WriteDataM_i;
          pcSrcW_d    = 1'b0;
          regWriteW_d = 1'b0;
          memToRegW_d = 1'b0;
        end else begin
          aluOutW_d   = ALUOutM_i;
          wa3W_d      = WA3M_i;
          pcSrcW_d    = PCSrcM_i;
          regWriteW_d = RegWriteM_i;
          memToRegW_d = MemToRegM_i;
        end
      end
      ST_WAIT: begin
        if (mem_ack_i) begin
          state_d     = ST_IDLE;
          req_d       = 1'b0;
          aluOutW_d   = ALUOutM_i;
          wa3W_d      = WA3M_i;
          pcSrcW_d    = PCSrcM_i;
          regWriteW_d = RegWriteM_i;
          memToRegW_d = MemToRegM_i;
          if (isLoad) readDataW_d = mem_rdata_i;
        end else if (timeoutHit) begin
          // Abort: keep the instruction's identity but suppress its effects.
          state_d     = ST_IDLE;
          req_d       = 1'b0;
          memErr_d    = 1'b1;
          aluOutW_d   = ALUOutM_i;
          wa3W_d      = WA3M_i;
          memToRegW_d = MemToRegM_i;
          pcSrcW_d    = 1'b0;
          regWriteW_d = 1'b0;
          readDataW_d = 32'd0;
        end else begin
          cnt_d       = cnt_q + 8'd1;
          pcSrcW_d    = 1'b0;
          regWriteW_d = 1'b0;
          memToRegW_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      readDataW_q <= 32'd0;
      aluOutW_q   <= 32'd0;
      wa3W_q      <= 4'd0;
      pcSrcW_q    <= 1'b0;
      regWriteW_q <= 1'b0;
      memToRegW_q <= 1'b0;
      memErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      readDataW_q <= readDataW_d;
      aluOutW_q   <= aluOutW_d;
      wa3W_q      <= wa3W_d;
      pcSrcW_q    <= pcSrcW_d;
      regWriteW_q <= regWriteW_d;
      memToRegW_q <= memToRegW_d;
      memErr_q    <= memErr_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign ReadDataW_o = readDataW_q;
  assign ALUOutW_o   = aluOutW_q;
  assign WA3W_o      = wa3W_q;
  assign PCSrcW_o    = pcSrcW_q;
  assign RegWriteW_o = regWriteW_q;
  assign MemToRegW_o = memToRegW_q;
  assign MemErr_o    = memErr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, load/store handshakes,
// timeout abort, async reset mid-access, ack-at-timeout and back-to-back loads.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUOutM, WriteDataM, mem_rdata;
  logic [3:0]  WA3M;
  logic        PCSrcM, RegWriteM, MemToRegM, MemWriteM, mem_ack;
  logic        mem_req, mem_we, StallM, PCSrcW, RegWriteW, MemToRegW, MemErr;
  logic [31:0] mem_addr, mem_wdata, ReadDataW, ALUOutW;
  logic [3:0]  WA3W;

  int checkCount = 0;
  int failCount  = 0;
  int reqCycles;

  mem_access_stage #(.TIMEOUT(15)) dut (
    .clk_i(clk), .reset_i(reset),
    .ALUOutM_i(ALUOutM), .WriteDataM_i(WriteDataM), .WA3M_i(WA3M),
    .PCSrcM_i(PCSrcM), .RegWriteM_i(RegWriteM), .MemToRegM_i(MemToRegM),
    .MemWriteM_i(MemWriteM),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .StallM_o(StallM), .ReadDataW_o(ReadDataW), .ALUOutW_o(ALUOutW),
    .WA3W_o(WA3W), .PCSrcW_o(PCSrcW), .RegWriteW_o(RegWriteW),
    .MemToRegW_o(MemToRegW), .MemErr_o(MemErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] wd,
                               input logic [3:0] wa, input logic rw,
                               input logic m2r, input logic mw);
    ALUOutM    = alu;
    WriteDataM = wd;
    WA3M       = wa;
    PCSrcM     = 1'b0;
    RegWriteM  = rw;
    MemToRegM  = m2r;
    MemWriteM  = mw;
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    applyStimulus(32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    #3;
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_stall", {31'd0, StallM}, 32'd0);
    checkOutput("rst_aluoutw", ALUOutW, 32'd0);
    checkOutput("rst_memerr", {31'd0, MemErr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // ALU op passes straight through in one cycle
    applyStimulus(32'h10, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("alu_stall", {31'd0, StallM}, 32'd0);
    tick();
    checkOutput("alu_aluoutw", ALUOutW, 32'h10);
    checkOutput("alu_wa3w", {28'd0, WA3W}, 32'd3);
    checkOutput("alu_regwritew", {31'd0, RegWriteW}, 32'd1);
    checkOutput("alu_stall_after", {31'd0, StallM}, 32'd0);

    // Load acked in the third WAIT cycle
    applyStimulus(32'h100, 32'h0, 4'd5, 1'b1, 1'b1, 1'b0);
    #1 checkOutput("ld_stall_idle", {31'd0, StallM}, 32'd1);
    tick();
    checkOutput("ld_req", {31'd0, mem_req}, 32'd1);
    checkOutput("ld_addr", mem_addr, 32'h100);
    checkOutput("ld_we", {31'd0, mem_we}, 32'd0);
    checkOutput("ld_bubble", {31'd0, RegWriteW}, 32'd0);
    checkOutput("ld_stall_w1", {31'd0, StallM}, 32'd1);
    tick();
    checkOutput("ld_stall_w2", {31'd0, StallM}, 32'd1);
    checkOutput("ld_req_w2", {31'd0, mem_req}, 32'd1);
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    #1 checkOutput("ld_stall_ack", {31'd0, StallM}, 32'd0);
    checkOutput("ld_req_w3", {31'd0, mem_req}, 32'd1);
    tick();
    mem_ack = 1'b0;
    applyStimulus(32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("ld_readdataw", ReadDataW, 32'hCAFEF00D);
    checkOutput("ld_memtoregw", {31'd0, MemToRegW}, 32'd1);
    checkOutput("ld_regwritew", {31'd0, RegWriteW}, 32'd1);
    checkOutput("ld_wa3w", {28'd0, WA3W}, 32'd5);
    checkOutput("ld_req_done", {31'd0, mem_req}, 32'd0);
    tick();
    checkOutput("ld_regwrite_once", {31'd0, RegWriteW}, 32'd0);

    // Store acked in the first WAIT cycle
    applyStimulus(32'h20, 32'h55, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("st_we", {31'd0, mem_we}, 32'd1);
    checkOutput("st_wdata", mem_wdata, 32'h55);
    checkOutput("st_addr", mem_addr, 32'h20);
    mem_ack = 1'b1;
    #1 checkOutput("st_stall_ack", {31'd0, StallM}, 32'd0);
    tick();
    mem_ack = 1'b0;
    applyStimulus(32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("st_req_done", {31'd0, mem_req}, 32'd0);
    checkOutput("st_regwritew", {31'd0, RegWriteW}, 32'd0);
    checkOutput("st_memerr", {31'd0, MemErr}, 32'd0);
    checkOutput("st_readdata_held", ReadDataW, 32'hCAFEF00D);

    // Load with no ack: abort after 15 request cycles
    applyStimulus(32'h300, 32'h0, 4'd7, 1'b1, 1'b1, 1'b0);
    tick();
    reqCycles = 0;
    while (mem_req && reqCycles < 40) begin
      reqCycles++;
      checkOutput("to_stall", {31'd0, StallM}, (reqCycles == 15) ? 32'd0 : 32'd1);
      tick();
    end
    applyStimulus(32'h44, 32'h0, 4'd2, 1'b1, 1'b0, 1'b0);
    checkOutput("to_req_cycles", reqCycles, 32'd15);
    checkOutput("to_memerr", {31'd0, MemErr}, 32'd1);
    checkOutput("to_regwritew", {31'd0, RegWriteW}, 32'd0);
    checkOutput("to_readdataw", ReadDataW, 32'd0);
    checkOutput("to_aluoutw", ALUOutW, 32'h300);
    tick();
    checkOutput("post_to_aluoutw", ALUOutW, 32'h44);
    checkOutput("post_to_regwritew", {31'd0, RegWriteW}, 32'd1);
    checkOutput("post_to_memerr", {31'd0, MemErr}, 32'd1);

    // Ack while idle is ignored
    applyStimulus(32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD;
    tick();
    mem_ack = 1'b0;
    checkOutput("idle_ack_readdata", ReadDataW, 32'd0);
    checkOutput("idle_ack_req", {31'd0, mem_req}, 32'd0);

    // Reset pulsed between edges mid-WAIT
    applyStimulus(32'h200, 32'h0, 4'd9, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    checkOutput("rw_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rw_stall", {31'd0, StallM}, 32'd0);
    checkOutput("rw_memerr", {31'd0, MemErr}, 32'd0);
    checkOutput("rw_aluoutw", ALUOutW, 32'd0);
    checkOutput("rw_wa3w", {28'd0, WA3W}, 32'd0);
    applyStimulus(32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h1234;
    tick();
    mem_ack = 1'b0;
    checkOutput("rw_late_ack_data", ReadDataW, 32'd0);
    checkOutput("rw_late_ack_rw", {31'd0, RegWriteW}, 32'd0);

    // Ack coincident with the timeout cycle wins
    applyStimulus(32'h500, 32'h0, 4'd4, 1'b1, 1'b1, 1'b0);
    tick();
    repeat (14) tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h77;
    #1 checkOutput("ackto_stall", {31'd0, StallM}, 32'd0);
    tick();
    mem_ack = 1'b0;
    applyStimulus(32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("ackto_memerr", {31'd0, MemErr}, 32'd0);
    checkOutput("ackto_readdata", ReadDataW, 32'h77);
    checkOutput("ackto_regwrite", {31'd0, RegWriteW}, 32'd1);

    // Back-to-back loads, each acked after one WAIT cycle
    applyStimulus(32'h400, 32'h0, 4'd1, 1'b1, 1'b1, 1'b0);
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h11111111;
    tick();
    mem_ack = 1'b0;
    applyStimulus(32'h404, 32'h0, 4'd2, 1'b1, 1'b1, 1'b0);
    checkOutput("b2b_a_rw", {31'd0, RegWriteW}, 32'd1);
    checkOutput("b2b_a_data", ReadDataW, 32'h11111111);
    checkOutput("b2b_a_wa3", {28'd0, WA3W}, 32'd1);
    checkOutput("b2b_a_req", {31'd0, mem_req}, 32'd0);
    #1 checkOutput("b2b_b_stall", {31'd0, StallM}, 32'd1);
    tick();
    checkOutput("b2b_b_req", {31'd0, mem_req}, 32'd1);
    checkOutput("b2b_b_addr", mem_addr, 32'h404);
    checkOutput("b2b_bubble", {31'd0, RegWriteW}, 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'h22222222;
    tick();
    mem_ack = 1'b0;
    applyStimulus(32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("b2b_b_rw", {31'd0, RegWriteW}, 32'd1);
    checkOutput("b2b_b_data", ReadDataW, 32'h22222222);
    checkOutput("b2b_b_wa3", {28'd0, WA3W}, 32'd2);
    tick();
    checkOutput("b2b_no_dup", {31'd0, RegWriteW}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
